// File: rtl/seq_counter_if.sv
// Control, table-write and status bundle for seq_counter.
// The master side drives the sequence controls and table writes, and the slave side returns the counter status.
interface seq_counter_if #(
  parameter int WIDTH = 4,
  parameter int PW    = 3
) ();
  logic             start;
  logic             enable;
  logic             loop;
  logic [PW-1:0]    last_phase;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] count;
  logic [PW-1:0]    phase;
  logic             running;
  logic             phase_done;
  logic             seq_done;

  modport master (
    output start, enable, loop, last_phase, wr_en, wr_addr, wr_data,
    input  count, phase, running, phase_done, seq_done
  );

  modport slave (
    input  start, enable, loop, last_phase, wr_en, wr_addr, wr_data,
    output count, phase, running, phase_done, seq_done
  );
endinterface

// File: rtl/seq_counter.sv
// Multi-phase sequence counter: each phase counts from 0 up to its own terminal value held in a
// writable limit table, with one-shot or looping sequences and registered done pulses.
module seq_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int PW    = 3
) (
  input  logic clock,
  input  logic reset,
  seq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [PW-1:0]    phase_q;
  logic             running_q;
  logic             phase_done_q;
  logic             seq_done_q;
  logic             loop_q;
  logic [PW-1:0]    last_q;

  logic [WIDTH-1:0] limit_q [DEPTH];

  logic [WIDTH-1:0] cur_limit_d;
  logic [PW-1:0]    last_phase_d;
  logic             phase_end_d;
  logic [WIDTH-1:0] count_inc_d;
  logic [PW-1:0]    phase_inc_d;

  // Out-of-range addresses match no entry, so those writes fall away naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        limit_q[i] <= '1;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wr_addr == PW'(i)) begin
          limit_q[i] <= bus.wr_data;
        end
      end
    end
  end

  always_comb begin
    cur_limit_d = limit_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (phase_q == PW'(i)) begin
        cur_limit_d = limit_q[i];
      end
    end
  end

  // Widened compare so the clamp still works when DEPTH equals 2**PW.
  always_comb begin
    if ({1'b0, bus.last_phase} >= (PW + 1)'(DEPTH)) begin
      last_phase_d = PW'(DEPTH - 1);
    end else begin
      last_phase_d = bus.last_phase;
    end
  end

  // Equality only: a limit lowered below the live count lets the count run on and wrap.
  assign phase_end_d = (count_q == cur_limit_d);
  assign count_inc_d = count_q + 1'b1;
  assign phase_inc_d = phase_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      phase_q      <= '0;
      running_q    <= 1'b0;
      phase_done_q <= 1'b0;
      seq_done_q   <= 1'b0;
      loop_q       <= 1'b0;
      last_q       <= '0;
    end else begin
      phase_done_q <= 1'b0;
      seq_done_q   <= 1'b0;
      if (bus.start) begin
        state_q   <= RUN;
        count_q   <= '0;
        phase_q   <= '0;
        running_q <= 1'b1;
        loop_q    <= bus.loop;
        last_q    <= last_phase_d;
      end else begin
        case (state_q)
          RUN: begin
            if (bus.enable) begin
              if (!phase_end_d) begin
                count_q <= count_inc_d;
              end else begin
                count_q      <= '0;
                phase_done_q <= 1'b1;
                if (phase_q < last_q) begin
                  phase_q <= phase_inc_d;
                end else begin
                  seq_done_q <= 1'b1;
                  if (loop_q) begin
                    phase_q <= '0;
                  end else begin
                    state_q   <= DONE;
                    running_q <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.phase      = phase_q;
  assign bus.running    = running_q;
  assign bus.phase_done = phase_done_q;
  assign bus.seq_done   = seq_done_q;

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: directed sequence scenarios followed by randomized traffic, all
// checked against a rule-level reference model.
module tb_seq_counter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 5;
  localparam int PW    = 3;
  localparam int MODW  = 1 << WIDTH;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_counter_if #(.WIDTH(WIDTH), .PW(PW)) bus_if ();

  seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit relaxed = 1'b0;

  // Reference state: 0 = idle, 1 = running, 2 = finished
  int m_state, m_cnt, m_ph, m_pd, m_sd, m_loop, m_last;
  int m_lim [DEPTH];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int lim_now;
    lim_now = m_lim[m_ph];
    m_pd = 0;
    m_sd = 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_ph = 0; m_loop = 0; m_last = 0;
      for (int i = 0; i < DEPTH; i++) m_lim[i] = MODW - 1;
    end else begin
      if (bus_if.start) begin
        m_state = 1; m_cnt = 0; m_ph = 0;
        m_loop  = int'(bus_if.loop);
        m_last  = (int'(bus_if.last_phase) >= DEPTH) ? DEPTH - 1 : int'(bus_if.last_phase);
      end else if (m_state == 1 && bus_if.enable) begin
        if (m_cnt == lim_now) begin
          m_cnt = 0;
          m_pd  = 1;
          if (m_ph < m_last) m_ph = m_ph + 1;
          else begin
            m_sd = 1;
            if (m_loop != 0) m_ph = 0;
            else m_state = 2;
          end
        end else begin
          m_cnt = (m_cnt + 1) % MODW;
        end
      end
      if (bus_if.wr_en && int'(bus_if.wr_addr) < DEPTH)
        m_lim[int'(bus_if.wr_addr)] = int'(bus_if.wr_data);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_val("count", int'(bus_if.count), m_cnt);
    if (!relaxed) begin
      check_val("phase", int'(bus_if.phase), m_ph);
      check_val("running", int'(bus_if.running), (m_state == 1) ? 1 : 0);
      check_val("phase_done", int'(bus_if.phase_done), m_pd);
      check_val("seq_done", int'(bus_if.seq_done), m_sd);
    end
  endtask

  task automatic write_entry(input int addr, input int data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = PW'(addr);
    bus_if.wr_data = WIDTH'(data);
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic start_seq(input int lp, input bit lp_loop);
    bus_if.start      = 1'b1;
    bus_if.loop       = lp_loop;
    bus_if.last_phase = PW'(lp);
    tick();
    bus_if.start      = 1'b0;
  endtask

  // Ticks until the selected pulse appears; n is the number of ticks taken.
  task automatic wait_pulse(input bit use_sd, input int budget, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = use_sd ? bus_if.seq_done : bus_if.phase_done;
    end
    if (!seen) check_val(use_sd ? "seq_done_timeout" : "phase_done_timeout", 0, 1);
  endtask

  task automatic wait_until(input int c, input int p, input int budget);
    int n;
    n = 0;
    while (!(int'(bus_if.count) == c && int'(bus_if.phase) == p) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_val("wait_until_timeout", 0, 1);
  endtask

  initial begin
    int n, pds;
    int lens [5];
    lens = '{13, 4, 2, 6, 11};

    bus_if.start = 1'b0; bus_if.enable = 1'b0; bus_if.loop = 1'b0;
    bus_if.last_phase = '0; bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;

    // Reset defaults and all-ones table
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("reset_count", int'(bus_if.count), 0);
    check_val("reset_running", int'(bus_if.running), 0);
    bus_if.enable = 1'b1;
    start_seq(0, 1'b1);
    check_val("start_running", int'(bus_if.running), 1);
    wait_pulse(1'b0, 40, n); check_val("default_len_first", n, 16);
    wait_pulse(1'b0, 40, n); check_val("default_len_next", n, 16);

    // Looping sequence 12,3,1,5,10
    bus_if.enable = 1'b0;
    write_entry(0, 12); write_entry(1, 3); write_entry(2, 1);
    write_entry(3, 5);  write_entry(4, 10);
    start_seq(4, 1'b1);
    bus_if.enable = 1'b1;
    for (int p = 0; p < 5; p++) begin
      wait_pulse(1'b0, 40, n);
      check_val($sformatf("loop_len_p%0d", p), n, lens[p]);
    end
    check_val("loop_sd_at_end", int'(bus_if.seq_done), 1);
    check_val("loop_wrap_phase", int'(bus_if.phase), 0);
    wait_pulse(1'b1, 80, n); check_val("loop_seq_period", n, 36);

    // One-shot with a zero limit
    bus_if.enable = 1'b0;
    write_entry(0, 0); write_entry(1, 2);
    start_seq(1, 1'b0);
    bus_if.enable = 1'b1;
    tick();
    check_val("oneshot_p0_end", int'(bus_if.phase_done), 1);
    tick(); tick(); tick();
    check_val("oneshot_sd", int'(bus_if.seq_done), 1);
    check_val("oneshot_running", int'(bus_if.running), 0);
    for (int k = 0; k < 6; k++) tick();
    check_val("oneshot_hold_count", int'(bus_if.count), 0);
    check_val("oneshot_hold_phase", int'(bus_if.phase), 1);

    // Pause and restart
    bus_if.enable = 1'b0;
    write_entry(0, 12); write_entry(1, 3); write_entry(2, 10);
    start_seq(4, 1'b1);
    bus_if.enable = 1'b1;
    wait_until(7, 0, 40);
    bus_if.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("pause_hold", int'(bus_if.count), 7);
    end
    bus_if.enable = 1'b1;
    wait_until(9, 2, 60);
    start_seq(4, 1'b1);
    check_val("restart_count", int'(bus_if.count), 0);
    check_val("restart_phase", int'(bus_if.phase), 0);
    check_val("restart_no_pd", int'(bus_if.phase_done), 0);
    check_val("restart_no_sd", int'(bus_if.seq_done), 0);

    // Live lowering of the active limit
    wait_until(8, 0, 20);
    write_entry(0, 5);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("live_no_end", int'(bus_if.phase_done), 0);
    end
    check_val("live_reach_15", int'(bus_if.count), 15);
    relaxed = 1'b1;
    tick();
    check_val("live_wrap", int'(bus_if.count), 0);

    // Ignored out-of-range write and last_phase clamp
    bus_if.enable = 1'b0;
    write_entry(6, 0);
    relaxed = 1'b0;
    bus_if.enable = 1'b1;
    start_seq(7, 1'b1);
    wait_pulse(1'b1, 100, n);
    pds = 0; n = 0;
    do begin
      tick();
      n++;
      if (bus_if.phase_done) pds++;
    end while (!bus_if.seq_done && n < 100);
    check_val("clamp_period", n, 38);
    check_val("clamp_phase_count", pds, 5);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset             = ($urandom_range(0, 299) == 0);
      bus_if.start      = (cyc == 0) || ($urandom_range(0, 39) == 0);
      bus_if.enable     = ($urandom_range(0, 3) != 0);
      bus_if.loop       = $urandom_range(0, 1);
      bus_if.last_phase = PW'($urandom_range(0, 7));
      bus_if.wr_en      = ($urandom_range(0, 7) == 0);
      bus_if.wr_addr    = PW'($urandom_range(0, 7));
      bus_if.wr_data    = WIDTH'($urandom_range(0, MODW - 1));
      if (bus_if.wr_en && !bus_if.start && m_state == 1 && int'(bus_if.wr_addr) == m_ph)
        bus_if.wr_en = 1'b0;
      tick();
    end
    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.wr_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
